// File: rtl/ycr1_dmi_arb_pkg.sv
// Shared types and widths for the two-requester DMI arbiter in front of ycr1_dm.
package ycr1_dmi_arb_pkg;

    localparam int YCR1_DBG_DMI_ADDR_WIDTH = 7;
    localparam int YCR1_DBG_DMI_DATA_WIDTH = 32;
    localparam int YCR1_DMI_ARB_TMO_W      = 8;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } type_ycr1_dmi_arb_fsm_e;

endpackage

// File: rtl/ycr1_dmi_arb_port.sv
// One requester's holding stage: captured request, pending/overflow flags,
// and the registered response (resp/err pulse plus read data).
module ycr1_dmi_arb_port
    import ycr1_dmi_arb_pkg::*;
#(
    parameter int ADDR_W = YCR1_DBG_DMI_ADDR_WIDTH,
    parameter int DATA_W = YCR1_DBG_DMI_DATA_WIDTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              wr,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              ovf_clr,
    input  logic              done,
    input  logic              tmo,
    input  logic [DATA_W-1:0] dm_rdata,
    output logic              pend,
    output logic              hold_wr,
    output logic [ADDR_W-1:0] hold_addr,
    output logic [DATA_W-1:0] hold_wdata,
    output logic              resp,
    output logic [DATA_W-1:0] rdata,
    output logic              err,
    output logic              ovf
);

    always_ff @(posedge clk) begin
        if (rst) begin
            pend       <= 1'b0;
            hold_wr    <= 1'b0;
            hold_addr  <= '0;
            hold_wdata <= '0;
            resp       <= 1'b0;
            rdata      <= '0;
            err        <= 1'b0;
            ovf        <= 1'b0;
        end else begin
            resp <= done;
            err  <= done & tmo;
            // done implies pend, so completion and a fresh capture never collide
            if (done) begin
                pend <= 1'b0;
                if (tmo) begin
                    rdata <= '0;
                end else if (!hold_wr) begin
                    rdata <= dm_rdata;
                end
            end
            if (req && !pend) begin
                pend       <= 1'b1;
                hold_wr    <= wr;
                hold_addr  <= addr;
                hold_wdata <= wdata;
            end
            // a dropped request outranks a clear in the same cycle
            if (req && pend) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ycr1_dmi_arb.sv
// Round-robin arbiter/sequencer for two DMI requesters sharing the DM slave port.
// Optional DM response timeout is enabled by defining YCR1_DMI_ARB_TIMEOUT_EN.
module ycr1_dmi_arb
    import ycr1_dmi_arb_pkg::*;
#(
    parameter int ADDR_W      = YCR1_DBG_DMI_ADDR_WIDTH,
    parameter int DATA_W      = YCR1_DBG_DMI_DATA_WIDTH,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   req_0_i,
    input  logic                   wr_0_i,
    input  logic [ADDR_W-1:0]      addr_0_i,
    input  logic [DATA_W-1:0]      wdata_0_i,
    input  logic                   ovf_clr_0_i,
    output logic                   resp_0_o,
    output logic [DATA_W-1:0]      rdata_0_o,
    output logic                   err_0_o,
    output logic                   busy_0_o,
    output logic                   ovf_0_o,
    input  logic                   req_1_i,
    input  logic                   wr_1_i,
    input  logic [ADDR_W-1:0]      addr_1_i,
    input  logic [DATA_W-1:0]      wdata_1_i,
    input  logic                   ovf_clr_1_i,
    output logic                   resp_1_o,
    output logic [DATA_W-1:0]      rdata_1_o,
    output logic                   err_1_o,
    output logic                   busy_1_o,
    output logic                   ovf_1_o,
    output logic                   dm_req_o,
    output logic                   dm_wr_o,
    output logic [ADDR_W-1:0]      dm_addr_o,
    output logic [DATA_W-1:0]      dm_wdata_o,
    input  logic                   dm_resp_i,
    input  logic [DATA_W-1:0]      dm_rdata_i,
    output type_ycr1_dmi_arb_fsm_e dbg_state
);

    if (TIMEOUT_CYC < 1 || TIMEOUT_CYC > 255) begin : g_bad_timeout
        $error("ycr1_dmi_arb: TIMEOUT_CYC must be within 1..255");
    end

    type_ycr1_dmi_arb_fsm_e state, state_nxt;
    logic              last_gnt, gnt_vld, gnt_sel;
    logic              issue, tmo, done_0, done_1;
    logic              pend_0, pend_1, hold_wr_0, hold_wr_1;
    logic [ADDR_W-1:0] hold_addr_0, hold_addr_1;
    logic [DATA_W-1:0] hold_wdata_0, hold_wdata_1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
        end else begin
            state <= state_nxt;
            if (gnt_vld) begin
                last_gnt <= gnt_sel;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        gnt_vld   = 1'b0;
        gnt_sel   = last_gnt;
        case (state)
            IDLE: begin
                if (pend_0 || pend_1) begin
                    gnt_vld   = 1'b1;
                    gnt_sel   = (pend_0 && pend_1) ? ~last_gnt : pend_1;
                    state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                if (dm_resp_i || tmo) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // last_gnt doubles as the owner of the transaction while in ISSUE
    always_comb begin
        issue      = (state == ISSUE);
        dbg_state  = state;
        dm_req_o   = issue;
        dm_wr_o    = 1'b0;
        dm_addr_o  = '0;
        dm_wdata_o = '0;
        if (issue) begin
            dm_wr_o    = last_gnt ? hold_wr_1    : hold_wr_0;
            dm_addr_o  = last_gnt ? hold_addr_1  : hold_addr_0;
            dm_wdata_o = last_gnt ? hold_wdata_1 : hold_wdata_0;
        end
        done_0 = issue && !last_gnt && (dm_resp_i || tmo);
        done_1 = issue &&  last_gnt && (dm_resp_i || tmo);
    end

`ifdef YCR1_DMI_ARB_TIMEOUT_EN
    logic [YCR1_DMI_ARB_TMO_W-1:0] tmo_cnt;

    always_ff @(posedge clk) begin
        if (rst || gnt_vld) begin
            tmo_cnt <= '0;
        end else if (issue && !dm_resp_i) begin
            tmo_cnt <= tmo_cnt + 1'b1;
        end
    end

    // fires on the last waiting cycle so dm_req_o stays up exactly TIMEOUT_CYC cycles
    assign tmo = issue && !dm_resp_i &&
                 (tmo_cnt == YCR1_DMI_ARB_TMO_W'(TIMEOUT_CYC - 1));
`else
    assign tmo = 1'b0;
`endif

    ycr1_dmi_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_0 (
        .clk        (clk),
        .rst        (rst),
        .req        (req_0_i),
        .wr         (wr_0_i),
        .addr       (addr_0_i),
        .wdata      (wdata_0_i),
        .ovf_clr    (ovf_clr_0_i),
        .done       (done_0),
        .tmo        (tmo),
        .dm_rdata   (dm_rdata_i),
        .pend       (pend_0),
        .hold_wr    (hold_wr_0),
        .hold_addr  (hold_addr_0),
        .hold_wdata (hold_wdata_0),
        .resp       (resp_0_o),
        .rdata      (rdata_0_o),
        .err        (err_0_o),
        .ovf        (ovf_0_o)
    );

    ycr1_dmi_arb_port #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_port_1 (
        .clk        (clk),
        .rst        (rst),
        .req        (req_1_i),
        .wr         (wr_1_i),
        .addr       (addr_1_i),
        .wdata      (wdata_1_i),
        .ovf_clr    (ovf_clr_1_i),
        .done       (done_1),
        .tmo        (tmo),
        .dm_rdata   (dm_rdata_i),
        .pend       (pend_1),
        .hold_wr    (hold_wr_1),
        .hold_addr  (hold_addr_1),
        .hold_wdata (hold_wdata_1),
        .resp       (resp_1_o),
        .rdata      (rdata_1_o),
        .err        (err_1_o),
        .ovf        (ovf_1_o)
    );

    assign busy_0_o = pend_0;
    assign busy_1_o = pend_1;

endmodule

// File: tb/tb_ycr1_dmi_arb.sv
// Self-checking bench for ycr1_dmi_arb: directed scenarios plus a randomized
// run against a transaction-level model of the arbiter.
module tb_ycr1_dmi_arb;
    import ycr1_dmi_arb_pkg::*;

    localparam int AW = 7;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic req_0_i, wr_0_i, ovf_clr_0_i, req_1_i, wr_1_i, ovf_clr_1_i;
    logic [AW-1:0] addr_0_i, addr_1_i;
    logic [DW-1:0] wdata_0_i, wdata_1_i;
    logic resp_0_o, err_0_o, busy_0_o, ovf_0_o, resp_1_o, err_1_o, busy_1_o, ovf_1_o;
    logic [DW-1:0] rdata_0_o, rdata_1_o;
    logic dm_req_o, dm_wr_o, dm_resp_i;
    logic [AW-1:0] dm_addr_o;
    logic [DW-1:0] dm_wdata_o, dm_rdata_i;
    type_ycr1_dmi_arb_fsm_e dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DW+1:0] exp_q[$];  // {port, err, rdata} of responses due next cycle

    ycr1_dmi_arb #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYC(8)) dut (
        .clk(clk), .rst(rst),
        .req_0_i(req_0_i), .wr_0_i(wr_0_i), .addr_0_i(addr_0_i), .wdata_0_i(wdata_0_i),
        .ovf_clr_0_i(ovf_clr_0_i), .resp_0_o(resp_0_o), .rdata_0_o(rdata_0_o),
        .err_0_o(err_0_o), .busy_0_o(busy_0_o), .ovf_0_o(ovf_0_o),
        .req_1_i(req_1_i), .wr_1_i(wr_1_i), .addr_1_i(addr_1_i), .wdata_1_i(wdata_1_i),
        .ovf_clr_1_i(ovf_clr_1_i), .resp_1_o(resp_1_o), .rdata_1_o(rdata_1_o),
        .err_1_o(err_1_o), .busy_1_o(busy_1_o), .ovf_1_o(ovf_1_o),
        .dm_req_o(dm_req_o), .dm_wr_o(dm_wr_o), .dm_addr_o(dm_addr_o),
        .dm_wdata_o(dm_wdata_o), .dm_resp_i(dm_resp_i), .dm_rdata_i(dm_rdata_i),
        .dbg_state(dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // driver tasks (all driving happens at the falling edge)
    task automatic clear_inputs();
        req_0_i = 0; wr_0_i = 0; addr_0_i = '0; wdata_0_i = '0; ovf_clr_0_i = 0;
        req_1_i = 0; wr_1_i = 0; addr_1_i = '0; wdata_1_i = '0; ovf_clr_1_i = 0;
        dm_resp_i = 0; dm_rdata_i = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 1;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    task automatic drive_port(input int p, input logic req, input logic wr,
                              input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                              input logic clr);
        if (p == 0) begin
            req_0_i = req; wr_0_i = wr; addr_0_i = addr; wdata_0_i = wdata; ovf_clr_0_i = clr;
        end else begin
            req_1_i = req; wr_1_i = wr; addr_1_i = addr; wdata_1_i = wdata; ovf_clr_1_i = clr;
        end
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if ({dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o} !== '0) begin n_fail++;
            $display("FAIL reset_dm: got req=%b addr=%h expected all zero", dm_req_o, dm_addr_o); end
        n_checks++; if ({busy_0_o, busy_1_o} !== 2'b00) begin n_fail++;
            $display("FAIL reset_busy: got %b%b expected 00", busy_0_o, busy_1_o); end
        n_checks++; if ({resp_0_o, resp_1_o, err_0_o, err_1_o} !== 4'b0) begin n_fail++;
            $display("FAIL reset_resp: got %b%b%b%b expected 0000", resp_0_o, resp_1_o, err_0_o, err_1_o); end
        n_checks++; if ({ovf_0_o, ovf_1_o} !== 2'b00) begin n_fail++;
            $display("FAIL reset_ovf: got %b%b expected 00", ovf_0_o, ovf_1_o); end
        n_checks++; if ({rdata_0_o, rdata_1_o} !== '0) begin n_fail++;
            $display("FAIL reset_rdata: got %h %h expected 0", rdata_0_o, rdata_1_o); end
        n_checks++; if (dbg_state !== IDLE) begin n_fail++;
            $display("FAIL reset_state: got %0d expected IDLE", dbg_state); end
    endtask

    task automatic test_read_basic();
        do_reset();
        drive_port(0, 1, 0, 7'h11, 32'h0, 0);
        @(negedge clk);  // cycle 1
        drive_port(0, 0, 0, '0, '0, 0);
        n_checks++; if ({busy_0_o, dm_req_o} !== 2'b10) begin n_fail++;
            $display("FAIL read_c1: got busy=%b dm_req=%b expected busy=1 dm_req=0", busy_0_o, dm_req_o); end
        @(negedge clk);  // cycle 2
        n_checks++; if ({dm_req_o, dm_wr_o, dm_addr_o} !== {1'b1, 1'b0, 7'h11}) begin n_fail++;
            $display("FAIL read_c2_dm: got req=%b wr=%b addr=%h expected 1 0 11", dm_req_o, dm_wr_o, dm_addr_o); end
        @(negedge clk);  // cycle 3
        dm_resp_i = 1; dm_rdata_i = 32'hDEADBEEF;
        @(negedge clk);  // cycle 4
        dm_resp_i = 0; dm_rdata_i = '0;
        n_checks++; if ({resp_0_o, err_0_o, busy_0_o, dm_req_o, resp_1_o} !== 5'b10000) begin n_fail++;
            $display("FAIL read_c4_flags: got resp=%b err=%b busy=%b dm_req=%b resp1=%b expected 1 0 0 0 0",
                      resp_0_o, err_0_o, busy_0_o, dm_req_o, resp_1_o); end
        n_checks++; if (rdata_0_o !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL read_c4_rdata: got %h expected deadbeef", rdata_0_o); end
        @(negedge clk);  // cycle 5
        n_checks++; if (resp_0_o !== 1'b0) begin n_fail++;
            $display("FAIL read_c5_pulse: got resp=%b expected 0", resp_0_o); end
    endtask

    task automatic test_simultaneous();
        logic [AW-1:0] order[$];
        logic [AW-1:0] exp_ord[4];
        logic [AW-1:0] got;
        int nr0 = 0;
        int nr1 = 0;
        exp_ord = '{7'h20, 7'h40, 7'h21, 7'h41};
        do_reset();
        for (int pair = 0; pair < 2; pair++) begin
            drive_port(0, 1, 0, exp_ord[2*pair], 32'h0, 0);
            drive_port(1, 1, 0, exp_ord[2*pair+1], 32'h0, 0);
            @(negedge clk);
            drive_port(0, 0, 0, '0, '0, 0);
            drive_port(1, 0, 0, '0, '0, 0);
            for (int i = 0; i < 12; i++) begin
                dm_resp_i = 0;
                if (resp_0_o) nr0++;
                if (resp_1_o) nr1++;
                if (dm_req_o) begin
                    order.push_back(dm_addr_o);
                    dm_resp_i = 1; dm_rdata_i = $urandom;
                end
                @(negedge clk);
            end
        end
        dm_resp_i = 0;
        n_checks++; if (order.size() !== 4) begin n_fail++;
            $display("FAIL simul_count: got %0d grants expected 4", order.size()); end
        for (int i = 0; i < 4; i++) begin
            got = (i < order.size()) ? order[i] : 'x;
            n_checks++; if (got !== exp_ord[i]) begin n_fail++;
                $display("FAIL simul_order[%0d]: got addr %h expected %h", i, got, exp_ord[i]); end
        end
        n_checks++; if (nr0 !== 2 || nr1 !== 2) begin n_fail++;
            $display("FAIL simul_resp: got %0d/%0d responses expected 2/2", nr0, nr1); end
    endtask

    task automatic test_write_delay();
        do_reset();
        drive_port(1, 1, 0, 7'h05, 32'h0, 0);
        @(negedge clk);
        drive_port(1, 0, 0, '0, '0, 0);
        @(negedge clk);
        dm_resp_i = 1; dm_rdata_i = 32'h13572468;
        @(negedge clk);
        dm_resp_i = 0;
        n_checks++; if ({resp_1_o, rdata_1_o} !== {1'b1, 32'h13572468}) begin n_fail++;
            $display("FAIL wr_preload: got resp=%b rdata=%h expected 1 13572468", resp_1_o, rdata_1_o); end
        drive_port(1, 1, 1, 7'h2A, 32'h5A5A0001, 0);
        @(negedge clk);
        drive_port(1, 0, 0, '0, '0, 0);
        @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if ({dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o, resp_1_o} !== {1'b1, 1'b1, 7'h2A, 32'h5A5A0001, 1'b0}) begin
                n_fail++;
                $display("FAIL wr_hold[%0d]: got req=%b wr=%b addr=%h wdata=%h resp=%b expected 1 1 2a 5a5a0001 0",
                         i, dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o, resp_1_o);
            end
            @(negedge clk);
        end
        dm_resp_i = 1; dm_rdata_i = 32'hFFFF0000;
        @(negedge clk);
        dm_resp_i = 0;
        n_checks++; if ({resp_1_o, err_1_o, rdata_1_o} !== {1'b1, 1'b0, 32'h13572468}) begin n_fail++;
            $display("FAIL wr_resp: got resp=%b err=%b rdata=%h expected 1 0 13572468", resp_1_o, err_1_o, rdata_1_o); end
        @(negedge clk);
        n_checks++; if ({resp_1_o, dm_req_o} !== 2'b00) begin n_fail++;
            $display("FAIL wr_single: got resp=%b dm_req=%b expected 0 0", resp_1_o, dm_req_o); end
    endtask

    task automatic test_overflow();
        do_reset();
        drive_port(0, 1, 0, 7'h22, 32'h0, 0);
        @(negedge clk);
        drive_port(0, 1, 1, 7'h33, 32'h99, 0);
        @(negedge clk);
        drive_port(0, 0, 0, '0, '0, 0);
        n_checks++; if ({ovf_0_o, ovf_1_o, dm_req_o, dm_wr_o, dm_addr_o} !== {4'b1010, 7'h22}) begin n_fail++;
            $display("FAIL ovf_set: got ovf=%b%b req=%b wr=%b addr=%h expected 10 1 0 22",
                     ovf_0_o, ovf_1_o, dm_req_o, dm_wr_o, dm_addr_o); end
        repeat (2) @(negedge clk);
        n_checks++; if ({ovf_0_o, dm_addr_o} !== {1'b1, 7'h22}) begin n_fail++;
            $display("FAIL ovf_hold: got ovf=%b addr=%h expected 1 22", ovf_0_o, dm_addr_o); end
        dm_resp_i = 1; dm_rdata_i = 32'hCAFE0022;
        @(negedge clk);
        dm_resp_i = 0;
        n_checks++; if ({resp_0_o, rdata_0_o, ovf_0_o} !== {1'b1, 32'hCAFE0022, 1'b1}) begin n_fail++;
            $display("FAIL ovf_first_done: got resp=%b rdata=%h ovf=%b expected 1 cafe0022 1", resp_0_o, rdata_0_o, ovf_0_o); end
        ovf_clr_0_i = 1;
        @(negedge clk);
        ovf_clr_0_i = 0;
        n_checks++; if (ovf_0_o !== 1'b0) begin n_fail++;
            $display("FAIL ovf_clr: got %b expected 0", ovf_0_o); end
        drive_port(0, 1, 0, 7'h44, 32'h0, 0);
        @(negedge clk);
        drive_port(0, 1, 0, 7'h45, 32'h0, 1);
        @(negedge clk);
        drive_port(0, 0, 0, '0, '0, 0);
        n_checks++; if ({ovf_0_o, dm_addr_o} !== {1'b1, 7'h44}) begin n_fail++;
            $display("FAIL ovf_set_wins: got ovf=%b addr=%h expected 1 44", ovf_0_o, dm_addr_o); end
        dm_resp_i = 1;
        @(negedge clk);
        dm_resp_i = 0;
        n_checks++; if ({resp_0_o, busy_0_o} !== 2'b10) begin n_fail++;
            $display("FAIL ovf_drain: got resp=%b busy=%b expected 1 0", resp_0_o, busy_0_o); end
    endtask

    task automatic test_rst_mid();
        do_reset();
        drive_port(0, 1, 0, 7'h15, 32'h0, 0);
        @(negedge clk);
        drive_port(0, 0, 0, '0, '0, 0);
        @(negedge clk);
        n_checks++; if (dm_req_o !== 1'b1) begin n_fail++;
            $display("FAIL rst_mid_issue: got dm_req=%b expected 1", dm_req_o); end
        @(negedge clk);  // cycle 3
        rst = 1; dm_resp_i = 1; dm_rdata_i = 32'h0BADF00D;
        @(negedge clk);
        rst = 0; dm_resp_i = 0;
        n_checks++; if ({dm_req_o, busy_0_o, resp_0_o} !== 3'b000) begin n_fail++;
            $display("FAIL rst_mid_abort: got dm_req=%b busy=%b resp=%b expected 000", dm_req_o, busy_0_o, resp_0_o); end
        @(negedge clk);
        n_checks++; if ({dm_req_o, resp_0_o, rdata_0_o} !== '0) begin n_fail++;
            $display("FAIL rst_mid_after: got dm_req=%b resp=%b rdata=%h expected 0 0 0", dm_req_o, resp_0_o, rdata_0_o); end
    endtask

    task automatic test_random();
        logic out[2];
        logic h_wr[2];
        logic [AW-1:0] h_addr[2];
        logic [DW-1:0] h_wdata[2];
        logic [DW-1:0] last_rd[2];
        logic ovf_m[2];
        logic issuing, next_issuing;
        int gport, last_port, lat;
        logic [DW-1:0] rd;
        logic exp_r, r_obs, e_obs, b_obs, o_obs, set_ev, clr, nw;
        logic [DW-1:0] d_obs, nd;
        logic [AW-1:0] na;
        do_reset();
        exp_q.delete();
        for (int p = 0; p < 2; p++) begin
            out[p] = 0; ovf_m[p] = 0; last_rd[p] = '0;
            h_wr[p] = 0; h_addr[p] = '0; h_wdata[p] = '0;
        end
        issuing = 0; gport = 0; last_port = 1; lat = 0;
        for (int cyc = 0; cyc < 800; cyc++) begin
            dm_resp_i = 0;
            for (int p = 0; p < 2; p++) begin
                exp_r = (exp_q.size() > 0) && (exp_q[0][DW+1] == 1'(p));
                r_obs = (p == 0) ? resp_0_o  : resp_1_o;
                e_obs = (p == 0) ? err_0_o   : err_1_o;
                d_obs = (p == 0) ? rdata_0_o : rdata_1_o;
                b_obs = (p == 0) ? busy_0_o  : busy_1_o;
                o_obs = (p == 0) ? ovf_0_o   : ovf_1_o;
                n_checks++; if (r_obs !== exp_r) begin n_fail++;
                    $display("FAIL rnd_resp%0d @%0d: got %b expected %b", p, cyc, r_obs, exp_r); end
                if (exp_r) begin
                    n_checks++; if ({e_obs, d_obs} !== exp_q[0][DW:0]) begin n_fail++;
                        $display("FAIL rnd_data%0d @%0d: got err=%b rdata=%h expected err=%b rdata=%h",
                                 p, cyc, e_obs, d_obs, exp_q[0][DW], exp_q[0][DW-1:0]); end
                    out[p] = 0;
                end
                n_checks++; if (b_obs !== out[p]) begin n_fail++;
                    $display("FAIL rnd_busy%0d @%0d: got %b expected %b", p, cyc, b_obs, out[p]); end
                n_checks++; if (o_obs !== ovf_m[p]) begin n_fail++;
                    $display("FAIL rnd_ovf%0d @%0d: got %b expected %b", p, cyc, o_obs, ovf_m[p]); end
            end
            if (exp_q.size() > 0) void'(exp_q.pop_front());

            n_checks++;
            if (issuing) begin
                if ({dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o} !== {1'b1, h_wr[gport], h_addr[gport], h_wdata[gport]}) begin
                    n_fail++;
                    $display("FAIL rnd_dm @%0d: got req=%b wr=%b addr=%h wdata=%h expected port %0d 1 %b %h %h",
                             cyc, dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o, gport, h_wr[gport], h_addr[gport], h_wdata[gport]);
                end
            end else if ({dm_req_o, dm_wr_o, dm_addr_o, dm_wdata_o} !== '0) begin
                n_fail++;
                $display("FAIL rnd_dm_idle @%0d: got req=%b addr=%h expected all zero", cyc, dm_req_o, dm_addr_o);
            end

            // DM responder and service order
            if (issuing) begin
                if (lat == 0) begin
                    rd = $urandom;
                    dm_resp_i = 1; dm_rdata_i = rd;
                    if (!h_wr[gport]) last_rd[gport] = rd;
                    exp_q.push_back({1'(gport), 1'b0, last_rd[gport]});
                    next_issuing = 0;
                end else begin
                    lat--;
                    dm_rdata_i = $urandom;
                    next_issuing = 1;
                end
            end else begin
                if ($urandom_range(0, 7) == 0) begin
                    dm_resp_i = 1; dm_rdata_i = $urandom;
                end
                if (out[0] || out[1]) begin
                    gport = (out[0] && out[1]) ? 1 - last_port : (out[0] ? 0 : 1);
                    last_port = gport;
                    lat = $urandom_range(0, 4);
                    next_issuing = 1;
                end else begin
                    next_issuing = 0;
                end
            end

            for (int p = 0; p < 2; p++) begin
                clr = ($urandom_range(0, 9) == 0);
                set_ev = 0;
                if ($urandom_range(0, 2) == 0) begin
                    nw = 1'($urandom); na = AW'($urandom); nd = $urandom;
                    drive_port(p, 1, nw, na, nd, clr);
                    set_ev = out[p];
                    if (!out[p]) begin
                        out[p] = 1; h_wr[p] = nw; h_addr[p] = na; h_wdata[p] = nd;
                    end
                end else begin
                    drive_port(p, 0, 0, '0, '0, clr);
                end
                if (set_ev) ovf_m[p] = 1;
                else if (clr) ovf_m[p] = 0;
            end
            issuing = next_issuing;
            @(negedge clk);
        end
        clear_inputs();
    endtask

`ifdef YCR1_DMI_ARB_TIMEOUT_EN
    task automatic test_timeout();
        do_reset();
        drive_port(0, 1, 0, 7'h31, 32'h0, 0);
        @(negedge clk);
        drive_port(0, 0, 0, '0, '0, 0);
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            n_checks++; if (dm_req_o !== 1'b1) begin n_fail++;
                $display("FAIL tmo_wait[%0d]: got dm_req=%b expected 1", i, dm_req_o); end
            @(negedge clk);
        end
        n_checks++; if ({dm_req_o, resp_0_o, err_0_o, busy_0_o, rdata_0_o} !== {4'b0110, 32'h0}) begin n_fail++;
            $display("FAIL tmo_fire: got dm_req=%b resp=%b err=%b busy=%b rdata=%h expected 0 1 1 0 0",
                     dm_req_o, resp_0_o, err_0_o, busy_0_o, rdata_0_o); end
        drive_port(1, 1, 0, 7'h32, 32'h0, 0);
        @(negedge clk);
        drive_port(1, 0, 0, '0, '0, 0);
        @(negedge clk);
        n_checks++; if ({dm_req_o, dm_addr_o} !== {1'b1, 7'h32}) begin n_fail++;
            $display("FAIL tmo_next_grant: got dm_req=%b addr=%h expected 1 32", dm_req_o, dm_addr_o); end
        dm_resp_i = 1; dm_rdata_i = 32'h00C0FFEE;
        @(negedge clk);
        dm_resp_i = 0;
        n_checks++; if ({resp_1_o, err_1_o, rdata_1_o} !== {2'b10, 32'h00C0FFEE}) begin n_fail++;
            $display("FAIL tmo_next_resp: got resp=%b err=%b rdata=%h expected 1 0 00c0ffee", resp_1_o, err_1_o, rdata_1_o); end
    endtask
`endif

    initial begin
        clear_inputs();
        test_reset();
        test_read_basic();
        test_simultaneous();
        test_write_delay();
        test_overflow();
        test_rst_mid();
        test_random();
`ifdef YCR1_DMI_ARB_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
